// File: rtl/ctrl_pipe.sv
// ctrl_pipe: control-bundle pipeline (ID/EX, EX/MEM, MEM/WB) for the 5-stage MIPS core,
// plus load-use stall, jump/branch flush and EX-stage forwarding selects.
// Optional performance counters (stall_cnt, flush_cnt) are enabled by defining
// CTRL_PIPE_PERF_CNT_EN.
module ctrl_pipe #(
  parameter int unsigned RA_W     = 5,
  parameter int unsigned LINK_REG = 31
`ifdef CTRL_PIPE_PERF_CNT_EN
  ,
  parameter int unsigned CNT_W    = 32
`endif
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [2:0]      id_jb,
  input  logic [3:0]      id_aluop,
  input  logic            id_regwrite,
  input  logic            id_memtoreg,
  input  logic            id_memwrite,
  input  logic            id_alusrc,
  input  logic            id_regdst,
  input  logic [RA_W-1:0] id_rs,
  input  logic [RA_W-1:0] id_rt,
  input  logic [RA_W-1:0] id_rd,
  input  logic            ex_br_taken,
  output logic            stall,
  output logic            flush_ifid,
  output logic            redirect,
  output logic [2:0]      ex_jb,
  output logic [3:0]      ex_aluop,
  output logic            ex_alusrc,
  output logic [RA_W-1:0] ex_rs,
  output logic [RA_W-1:0] ex_rt,
  output logic [RA_W-1:0] ex_wreg,
  output logic            mem_regwrite,
  output logic            mem_memtoreg,
  output logic            mem_memwrite,
  output logic [RA_W-1:0] mem_wreg,
  output logic            wb_regwrite,
  output logic            wb_memtoreg,
  output logic [RA_W-1:0] wb_wreg,
  output logic [1:0]      fwd_a,
  output logic [1:0]      fwd_b
`ifdef CTRL_PIPE_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
`endif
);

  localparam logic [2:0] JB_BEQ = 3'b001;
  localparam logic [2:0] JB_BNE = 3'b010;
  localparam logic [2:0] JB_JR  = 3'b011;
  localparam logic [2:0] JB_J   = 3'b100;
  localparam logic [2:0] JB_JAL = 3'b111;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_MEM = 2'b01;
  localparam logic [1:0] FWD_WB  = 2'b10;

  // ID/EX control bits not exported as ports
  logic ex_regwrite;
  logic ex_memtoreg;
  logic ex_memwrite;

  logic [RA_W-1:0] id_wreg;
  logic            id_reads_rs;
  logic            id_reads_rt;
  logic            id_is_jump;
  logic            hz;
  logic            bubble;

  // ID decode, hazard detection and redirect/flush decisions
  always_comb begin
    id_wreg     = id_regdst ? id_rd : id_rt;
    if (id_jb == JB_JAL) begin
      id_wreg = RA_W'(LINK_REG);
    end
    id_is_jump  = (id_jb == JB_J) || (id_jb == JB_JAL);
    id_reads_rs = !id_is_jump;
    id_reads_rt = id_regdst || id_memwrite || (id_jb == JB_BEQ) || (id_jb == JB_BNE);

    hz = ex_memtoreg && (ex_wreg != '0) &&
         ((id_reads_rs && (ex_wreg == id_rs)) || (id_reads_rt && (ex_wreg == id_rt)));

    // reset suppresses any stall/flush decision in flight
    redirect   = !rst && ex_br_taken &&
                 ((ex_jb == JB_BEQ) || (ex_jb == JB_BNE) || (ex_jb == JB_JR));
    stall      = !rst && hz && !redirect;
    flush_ifid = !rst && (redirect || (id_is_jump && !stall));
    bubble     = stall || redirect;
  end

  // EX-stage forwarding; EX/MEM wins over MEM/WB, $0 never forwarded
  always_comb begin
    fwd_a = FWD_RF;
    fwd_b = FWD_RF;
    if (mem_regwrite && (mem_wreg != '0) && (mem_wreg == ex_rs)) begin
      fwd_a = FWD_MEM;
    end else if (wb_regwrite && (wb_wreg != '0) && (wb_wreg == ex_rs)) begin
      fwd_a = FWD_WB;
    end
    if (mem_regwrite && (mem_wreg != '0) && (mem_wreg == ex_rt)) begin
      fwd_b = FWD_MEM;
    end else if (wb_regwrite && (wb_wreg != '0) && (wb_wreg == ex_rt)) begin
      fwd_b = FWD_WB;
    end
  end

  // ID/EX register: takes the ID bundle or a bubble on stall/redirect
  always_ff @(posedge clk) begin
    if (rst || bubble) begin
      ex_jb       <= '0;
      ex_aluop    <= '0;
      ex_alusrc   <= 1'b0;
      ex_rs       <= '0;
      ex_rt       <= '0;
      ex_wreg     <= '0;
      ex_regwrite <= 1'b0;
      ex_memtoreg <= 1'b0;
      ex_memwrite <= 1'b0;
    end else begin
      ex_jb       <= id_jb;
      ex_aluop    <= id_aluop;
      ex_alusrc   <= id_alusrc;
      ex_rs       <= id_rs;
      ex_rt       <= id_rt;
      ex_wreg     <= id_wreg;
      ex_regwrite <= id_regwrite;
      ex_memtoreg <= id_memtoreg;
      ex_memwrite <= id_memwrite;
    end
  end

  // EX/MEM and MEM/WB always advance
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_regwrite <= 1'b0;
      mem_memtoreg <= 1'b0;
      mem_memwrite <= 1'b0;
      mem_wreg     <= '0;
      wb_regwrite  <= 1'b0;
      wb_memtoreg  <= 1'b0;
      wb_wreg      <= '0;
    end else begin
      mem_regwrite <= ex_regwrite;
      mem_memtoreg <= ex_memtoreg;
      mem_memwrite <= ex_memwrite;
      mem_wreg     <= ex_wreg;
      wb_regwrite  <= mem_regwrite;
      wb_memtoreg  <= mem_memtoreg;
      wb_wreg      <= mem_wreg;
    end
  end

`ifdef CTRL_PIPE_PERF_CNT_EN
  // stall and flush event counters, wrapping
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (stall) begin
        stall_cnt <= stall_cnt + CNT_W'(1);
      end
      if (redirect || flush_ifid) begin
        flush_cnt <= flush_cnt + CNT_W'(1);
      end
    end
  end
`endif

endmodule

// File: tb/tb_ctrl_pipe.sv
// Self-checking bench for ctrl_pipe: directed scenarios with literal expectations,
// then randomized traffic compared each cycle against a stage-list reference model.
module tb_ctrl_pipe;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] id_jb;
  logic [3:0] id_aluop;
  logic       id_regwrite, id_memtoreg, id_memwrite, id_alusrc, id_regdst;
  logic [4:0] id_rs, id_rt, id_rd;
  logic       ex_br_taken;
  logic       stall, flush_ifid, redirect;
  logic [2:0] ex_jb;
  logic [3:0] ex_aluop;
  logic       ex_alusrc;
  logic [4:0] ex_rs, ex_rt, ex_wreg;
  logic       mem_regwrite, mem_memtoreg, mem_memwrite;
  logic [4:0] mem_wreg;
  logic       wb_regwrite, wb_memtoreg;
  logic [4:0] wb_wreg;
  logic [1:0] fwd_a, fwd_b;
`ifdef CTRL_PIPE_PERF_CNT_EN
  logic [31:0] stall_cnt, flush_cnt;
  logic [31:0] m_stall_cnt, m_flush_cnt;
`endif

  always #5 clk = ~clk;

  ctrl_pipe dut (
    .clk(clk), .rst(rst),
    .id_jb(id_jb), .id_aluop(id_aluop),
    .id_regwrite(id_regwrite), .id_memtoreg(id_memtoreg), .id_memwrite(id_memwrite),
    .id_alusrc(id_alusrc), .id_regdst(id_regdst),
    .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
    .ex_br_taken(ex_br_taken),
    .stall(stall), .flush_ifid(flush_ifid), .redirect(redirect),
    .ex_jb(ex_jb), .ex_aluop(ex_aluop), .ex_alusrc(ex_alusrc),
    .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_wreg(ex_wreg),
    .mem_regwrite(mem_regwrite), .mem_memtoreg(mem_memtoreg), .mem_memwrite(mem_memwrite),
    .mem_wreg(mem_wreg),
    .wb_regwrite(wb_regwrite), .wb_memtoreg(wb_memtoreg), .wb_wreg(wb_wreg),
    .fwd_a(fwd_a), .fwd_b(fwd_b)
`ifdef CTRL_PIPE_PERF_CNT_EN
    , .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
`endif
  );

  // One in-flight instruction as the model sees it
  typedef struct packed {
    logic       rw;
    logic       mtr;
    logic       mw;
    logic       as;
    logic [2:0] jb;
    logic [3:0] op;
    logic [4:0] rs;
    logic [4:0] rt;
    logic [4:0] wreg;
  } ins_t;

  ins_t pipe [3];   // 0 = EX, 1 = MEM, 2 = WB
  logic e_stall, e_flush, e_red;
  int   n_chk = 0;
  int   n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  function automatic logic [1:0] fwd_sel(input logic [4:0] src);
    if (pipe[1].rw && pipe[1].wreg != 0 && pipe[1].wreg == src) return 2'b01;
    if (pipe[2].rw && pipe[2].wreg != 0 && pipe[2].wreg == src) return 2'b10;
    return 2'b00;
  endfunction

  function automatic ins_t id_ins();
    ins_t i;
    i.rw   = id_regwrite;
    i.mtr  = id_memtoreg;
    i.mw   = id_memwrite;
    i.as   = id_alusrc;
    i.jb   = id_jb;
    i.op   = id_aluop;
    i.rs   = id_rs;
    i.rt   = id_rt;
    i.wreg = (id_jb == 3'b111) ? 5'd31 : (id_regdst ? id_rd : id_rt);
    return i;
  endfunction

  // Settle, derive expected outputs from the model, compare everything
  task automatic check_cycle();
    logic use_rs, use_rt, hz;
    #1;
    use_rs  = !(id_jb == 3'b100 || id_jb == 3'b111);
    use_rt  = id_regdst || id_memwrite || id_jb == 3'b001 || id_jb == 3'b010;
    hz      = pipe[0].mtr && pipe[0].wreg != 0 &&
              ((use_rs && pipe[0].wreg == id_rs) || (use_rt && pipe[0].wreg == id_rt));
    e_red   = !rst && ex_br_taken && (pipe[0].jb inside {3'b001, 3'b010, 3'b011});
    e_stall = !rst && hz && !e_red;
    e_flush = !rst && (e_red || ((id_jb == 3'b100 || id_jb == 3'b111) && !e_stall));
    chk("stall", 32'(stall), 32'(e_stall));
    chk("flush_ifid", 32'(flush_ifid), 32'(e_flush));
    chk("redirect", 32'(redirect), 32'(e_red));
    chk("ex_jb", 32'(ex_jb), 32'(pipe[0].jb));
    chk("ex_aluop", 32'(ex_aluop), 32'(pipe[0].op));
    chk("ex_alusrc", 32'(ex_alusrc), 32'(pipe[0].as));
    chk("ex_rs", 32'(ex_rs), 32'(pipe[0].rs));
    chk("ex_rt", 32'(ex_rt), 32'(pipe[0].rt));
    chk("ex_wreg", 32'(ex_wreg), 32'(pipe[0].wreg));
    chk("mem_regwrite", 32'(mem_regwrite), 32'(pipe[1].rw));
    chk("mem_memtoreg", 32'(mem_memtoreg), 32'(pipe[1].mtr));
    chk("mem_memwrite", 32'(mem_memwrite), 32'(pipe[1].mw));
    chk("mem_wreg", 32'(mem_wreg), 32'(pipe[1].wreg));
    chk("wb_regwrite", 32'(wb_regwrite), 32'(pipe[2].rw));
    chk("wb_memtoreg", 32'(wb_memtoreg), 32'(pipe[2].mtr));
    chk("wb_wreg", 32'(wb_wreg), 32'(pipe[2].wreg));
    chk("fwd_a", 32'(fwd_a), 32'(fwd_sel(pipe[0].rs)));
    chk("fwd_b", 32'(fwd_b), 32'(fwd_sel(pipe[0].rt)));
`ifdef CTRL_PIPE_PERF_CNT_EN
    chk("stall_cnt", stall_cnt, m_stall_cnt);
    chk("flush_cnt", flush_cnt, m_flush_cnt);
`endif
  endtask

  // Move the model one clock forward alongside the DUT, return at the next negedge
  task automatic advance();
    ins_t nx [3];
    nx[2] = pipe[1];
    nx[1] = pipe[0];
    nx[0] = (rst || e_stall || e_red) ? ins_t'(0) : id_ins();
    if (rst) begin
      nx[0] = '0; nx[1] = '0; nx[2] = '0;
    end
    @(posedge clk);
    pipe = nx;
`ifdef CTRL_PIPE_PERF_CNT_EN
    if (rst) begin
      m_stall_cnt = 0; m_flush_cnt = 0;
    end else begin
      if (e_stall) m_stall_cnt++;
      if (e_red || e_flush) m_flush_cnt++;
    end
`endif
    @(negedge clk);
  endtask

  task automatic set_id(input logic [2:0] jb, input logic rw, input logic mtr, input logic mw,
                        input logic as, input logic rdst, input logic [4:0] rs,
                        input logic [4:0] rt, input logic [4:0] rd, input logic br);
    id_jb = jb; id_aluop = 4'(rs + rt); id_regwrite = rw; id_memtoreg = mtr;
    id_memwrite = mw; id_alusrc = as; id_regdst = rdst;
    id_rs = rs; id_rt = rt; id_rd = rd; ex_br_taken = br;
  endtask

  task automatic set_rand(input int rng);
    id_jb = 3'($urandom_range(0, 7)); id_aluop = 4'($urandom);
    id_regwrite = 1'($urandom); id_memtoreg = 1'($urandom); id_memwrite = 1'($urandom);
    id_alusrc = 1'($urandom); id_regdst = 1'($urandom);
    id_rs = 5'($urandom_range(0, rng)); id_rt = 5'($urandom_range(0, rng));
    id_rd = 5'($urandom_range(0, rng)); ex_br_taken = 1'($urandom);
  endtask

  task automatic nop();
    set_id(3'b000, 0, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0);
  endtask

  initial begin
    pipe[0] = '0; pipe[1] = '0; pipe[2] = '0;
`ifdef CTRL_PIPE_PERF_CNT_EN
    m_stall_cnt = 0; m_flush_cnt = 0;
`endif
    // Reset held two edges with random ID inputs
    rst = 1'b1;
    set_rand(31);
    @(posedge clk);
    @(negedge clk);
    set_rand(31);
    check_cycle();
    chk("rst_stall", 32'(stall), 32'd0);
    chk("rst_flush", 32'(flush_ifid), 32'd0);
    chk("rst_ex_wreg", 32'(ex_wreg), 32'd0);
    chk("rst_wb_regwrite", 32'(wb_regwrite), 32'd0);
    advance();
    rst = 1'b0;
    nop(); check_cycle(); advance();

    // ADD $3,$1,$2 ; SUB $4,$3,$3 ; OR $7,$3,$8
    set_id(3'b000, 1, 0, 0, 0, 1, 5'd1, 5'd2, 5'd3, 0); check_cycle(); advance();
    set_id(3'b000, 1, 0, 0, 0, 1, 5'd3, 5'd3, 5'd4, 0); check_cycle(); advance();
    set_id(3'b000, 1, 0, 0, 0, 1, 5'd3, 5'd8, 5'd7, 0); check_cycle();
    chk("sub_fwd_a", 32'(fwd_a), 32'd1);
    chk("sub_fwd_b", 32'(fwd_b), 32'd1);
    advance();
    nop(); check_cycle();
    chk("or_fwd_a", 32'(fwd_a), 32'd2);
    chk("or_fwd_b", 32'(fwd_b), 32'd0);
    advance();
    nop(); check_cycle(); advance();
    nop(); check_cycle(); advance();

    // LW $5,0($1) ; ADD $6,$5,$2
    set_id(3'b000, 1, 1, 0, 1, 0, 5'd1, 5'd5, 5'd0, 0); check_cycle(); advance();
    set_id(3'b000, 1, 0, 0, 0, 1, 5'd5, 5'd2, 5'd6, 0); check_cycle();
    chk("lu_stall", 32'(stall), 32'd1);
    chk("lu_flush", 32'(flush_ifid), 32'd0);
    advance();
    check_cycle();
    chk("lu_stall_once", 32'(stall), 32'd0);
    chk("lu_bubble_wreg", 32'(ex_wreg), 32'd0);
    advance();
    nop(); check_cycle();
    chk("lu_fwd_a", 32'(fwd_a), 32'd2);
    chk("lu_fwd_b", 32'(fwd_b), 32'd0);
    advance();
    nop(); check_cycle(); advance();
    nop(); check_cycle(); advance();

    // Taken BEQ in EX while a load-use candidate sits in ID
    set_id(3'b001, 0, 0, 0, 0, 0, 5'd1, 5'd2, 5'd0, 0); check_cycle(); advance();
    set_id(3'b000, 1, 1, 0, 1, 0, 5'd1, 5'd5, 5'd0, 1); check_cycle();
    chk("br_redirect", 32'(redirect), 32'd1);
    chk("br_flush", 32'(flush_ifid), 32'd1);
    chk("br_stall", 32'(stall), 32'd0);
    advance();
    set_id(3'b000, 1, 0, 0, 0, 1, 5'd5, 5'd2, 5'd6, 0); check_cycle();
    chk("br_bubble_wreg", 32'(ex_wreg), 32'd0);
    chk("br_no_stall", 32'(stall), 32'd0);
    chk("br_redirect_off", 32'(redirect), 32'd0);
    advance();
    nop(); check_cycle(); advance();
    nop(); check_cycle(); advance();

    // JAL in ID
    set_id(3'b111, 1, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0); check_cycle();
    chk("jal_flush", 32'(flush_ifid), 32'd1);
    advance();
    nop(); check_cycle(); advance();
    nop(); check_cycle(); advance();
    nop(); check_cycle();
    chk("jal_wb_wreg", 32'(wb_wreg), 32'd31);
    chk("jal_wb_regwrite", 32'(wb_regwrite), 32'd1);
    advance();

    // ADDI $0,$0,7 then a reader of $0; LW $0 then a reader of $0
    set_id(3'b000, 1, 0, 0, 1, 0, 5'd0, 5'd0, 5'd0, 0); check_cycle(); advance();
    set_id(3'b000, 1, 0, 0, 0, 1, 5'd0, 5'd0, 5'd9, 0); check_cycle(); advance();
    nop(); check_cycle();
    chk("r0_fwd_a", 32'(fwd_a), 32'd0);
    chk("r0_fwd_b", 32'(fwd_b), 32'd0);
    advance();
    set_id(3'b000, 1, 1, 0, 1, 0, 5'd1, 5'd0, 5'd0, 0); check_cycle(); advance();
    set_id(3'b000, 1, 0, 0, 0, 1, 5'd0, 5'd0, 5'd9, 0); check_cycle();
    chk("r0_no_stall", 32'(stall), 32'd0);
    advance();
    nop(); check_cycle(); advance();
`ifdef CTRL_PIPE_PERF_CNT_EN
    chk("perf_stall_cnt", stall_cnt, 32'd1);
    chk("perf_flush_cnt", flush_cnt, 32'd2);
`endif

    // Randomized traffic, narrow register range to provoke hazards
    for (int c = 0; c < 3000; c++) begin
      rst = ($urandom_range(0, 99) == 0);
      set_rand((c % 4 == 0) ? 31 : 3);
      check_cycle();
      advance();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
